// File: rtl/sorter_pkg.sv
// Shared types and constants for the sorter frame sequencer and its watchdog.
// The sequencer is the only master of the Sorter user port, start and reset.
package sorter_pkg;

    localparam int unsigned SORT_WORDS = 8;
    localparam int unsigned SORT_AW    = 3;
    localparam int unsigned DATA_W     = 8;

    typedef enum logic [2:0] {
        LOAD,
        KICK,
        WAIT,
        DRAIN,
        FAULT
    } seq_state_t;

endpackage

// File: rtl/sort_watchdog.sv
// Saturating cycle counter with synchronous clear; flags expiry at LIMIT.
// Used to bound how long the sequencer waits for the Sorter to finish.
module sort_watchdog #(
    parameter int unsigned LIMIT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic count,
    output logic expired
);

    localparam int unsigned W = $clog2(LIMIT + 1);

    logic [W-1:0] value;

    always_ff @(posedge clk) begin
        if (rst) begin
            value <= '0;
        end else if (load) begin
            value <= '0;
        end else if (count && (value != W'(LIMIT))) begin
            value <= value + 1'b1;
        end
    end

    assign expired = (value == W'(LIMIT));

endmodule

// File: rtl/sort_frame_sequencer.sv
// Streams one 8-byte frame into the Sorter RAM, kicks a sort under a watchdog,
// then drains the sorted bytes in address order to a valid/ready consumer.
module sort_frame_sequencer
    import sorter_pkg::*;
#(
    parameter int unsigned N_WORDS  = SORT_WORDS,
    parameter int unsigned WATCHDOG = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_last,
    output logic              busy,
    output logic              err,
    output logic              sort_nrst,
    output logic              sort_start,
    output logic              sort_wr,
    output logic [SORT_AW-1:0] sort_addr,
    output logic [DATA_W-1:0] sort_datain,
    input  logic              sort_ready,
    input  logic [DATA_W-1:0] sort_dataout
);

    localparam logic [SORT_AW-1:0] LAST = SORT_AW'(N_WORDS - 1);

    seq_state_t         state;
    seq_state_t         state_next;
    logic [SORT_AW-1:0] cnt;
    logic [SORT_AW-1:0] cnt_next;
    logic               rd_ok;
    logic               rd_ok_next;
    logic               wd_load;
    logic               wd_count;
    logic               wd_expired;
    logic               in_hs;
    logic               out_hs;

    sort_watchdog #(
        .LIMIT(WATCHDOG)
    ) u_watchdog (
        .clk    (clk),
        .rst    (rst),
        .load   (wd_load),
        .count  (wd_count),
        .expired(wd_expired)
    );

    always_comb begin
        state_next  = state;
        cnt_next    = cnt;
        rd_ok_next  = rd_ok;
        s_ready     = 1'b0;
        sort_wr     = 1'b0;
        sort_addr   = '0;
        sort_datain = '0;
        sort_start  = 1'b0;
        m_valid     = 1'b0;
        m_data      = '0;
        m_last      = 1'b0;
        wd_load     = 1'b0;
        wd_count    = 1'b0;
        in_hs       = 1'b0;
        out_hs      = 1'b0;

        case (state)
            LOAD: begin
                s_ready     = sort_nrst & sort_ready;
                in_hs       = s_valid & sort_nrst & sort_ready;
                // rst in the same cycle must keep the byte out of the Sorter RAM
                sort_wr     = in_hs & ~rst;
                sort_addr   = cnt;
                sort_datain = s_data;
                if (in_hs) begin
                    cnt_next = cnt + 1'b1;
                    if (cnt == LAST) begin
                        cnt_next   = '0;
                        state_next = KICK;
                    end
                end
            end
            KICK: begin
                sort_start = 1'b1;
                wd_load    = 1'b1;
                state_next = WAIT;
            end
            WAIT: begin
                wd_count = 1'b1;
                if (sort_ready) begin
                    state_next = DRAIN;
                    cnt_next   = '0;
                    rd_ok_next = 1'b0;
                end else if (wd_expired) begin
                    state_next = FAULT;
                end
            end
            DRAIN: begin
                sort_addr = cnt;
                m_valid   = rd_ok;
                m_data    = sort_dataout;
                m_last    = rd_ok & (cnt == LAST);
                out_hs    = rd_ok & m_ready;
                // read data is valid once the address has been held for one edge
                if (out_hs) begin
                    rd_ok_next = 1'b0;
                    cnt_next   = cnt + 1'b1;
                    if (cnt == LAST) begin
                        cnt_next   = '0;
                        state_next = LOAD;
                    end
                end else begin
                    rd_ok_next = 1'b1;
                end
            end
            FAULT: begin
                cnt_next   = '0;
                state_next = LOAD;
            end
            default: begin
                cnt_next   = '0;
                state_next = LOAD;
            end
        endcase
    end

    assign busy = ~((state == LOAD) && (cnt == '0));

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= LOAD;
            cnt       <= '0;
            rd_ok     <= 1'b0;
            err       <= 1'b0;
            sort_nrst <= 1'b0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            rd_ok     <= rd_ok_next;
            sort_nrst <= (state != FAULT);
            if (state == FAULT) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: doc/sort_frame_sequencer.md
Name: sort_frame_sequencer

Overview:
Sequences one `Sorter` instance as a streaming unit.
- Loads an 8-byte frame from an input valid/ready stream into the sorter RAM through the sorter's user port.
- Pulses `start`, waits for completion under a watchdog, then drains the 8 sorted bytes in address order to an output valid/ready stream.
- Sits between a byte producer/consumer and the `Sorter`. It is the sole master of the sorter's `wr`/`addr`/`datain`/`start`/`nrst`.

Parameters:
- `N_WORDS`, 8: frame length; must equal sorter RAM depth (address width `$clog2(N_WORDS)`=3).
- `WATCHDOG`, 255: max cycles allowed in WAIT before declaring a fault.

Ports:
- `clk`  in  1  system clock, all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `s_data`  in  8  input byte
- `s_valid`  in  1  input byte valid
- `s_ready`  out  1  sequencer accepts input byte
- `m_data`  out  8  sorted output byte
- `m_valid`  out  1  output byte valid
- `m_ready`  in  1  consumer accepts output byte
- `m_last`  out  1  marks 8th output byte of frame (qualified by `m_valid`)
- `busy`  out  1  high in every state except LOAD with `cnt`=0
- `err`  out  1  sticky watchdog fault flag
- `sort_nrst`  out  1  registered active-low reset to `Sorter`
- `sort_start`  out  1  start pulse to `Sorter`
- `sort_wr`  out  1  write strobe to `Sorter` user port
- `sort_addr`  out  3  address to `Sorter` user port
- `sort_datain`  out  8  write data to `Sorter`
- `sort_ready`  in  1  `Sorter` ready (idle)
- `sort_dataout`  in  8  `Sorter` synchronous read data (1-cycle latency from `sort_addr`)

Behaviour:
- Reset (`rst`=1 at edge):
  - state=LOAD, `cnt`=0, `rd_ok`=0, `wd`=0, `err`=0, `sort_nrst`=0.
  - The cycle after `rst` deasserts, `sort_nrst`=1.
  - All outputs are low except as derived below.
  - Reset mid-frame discards the frame; no partial output.
- States: LOAD, KICK, WAIT, DRAIN, FAULT. `cnt` is 3-bit, wraps 7->0.
- LOAD:
  - `s_ready`=`sort_nrst`&`sort_ready`; `sort_wr`=`s_valid`&`s_ready`; `sort_addr`=`cnt`; `sort_datain`=`s_data`.
  - On handshake, `cnt`++.
  - On handshake with `cnt`=7: `cnt`->0, go KICK.
  - `sort_start`=0 throughout.
- KICK (exactly 1 cycle): `sort_start`=1, `s_ready`=0, `sort_wr`=0. Next state WAIT, `wd`=0.
- WAIT:
  - `sort_start`=0, `wd`++ each cycle.
  - `sort_ready`=1 (first seen no earlier than the 2nd WAIT cycle; the `Sorter` drops `ready` the cycle after start): go DRAIN, `cnt`=0, `rd_ok`=0.
  - `wd`==`WATCHDOG` while `sort_ready`=0: go FAULT.
- DRAIN:
  - `sort_addr`=`cnt`, `sort_wr`=0.
  - `rd_ok` registers 1 the cycle after `sort_addr` has been stable one cycle: `rd_ok`<=1 unless a handshake occurs.
  - `m_valid`=`rd_ok`; `m_data`=`sort_dataout` (combinational pass-through); `m_last`=`rd_ok`&(`cnt`==7).
  - On `m_valid`&`m_ready`: `cnt`++, `rd_ok`<=0.
  - If `cnt`==7 on that handshake: `cnt`->0, go LOAD.
  - Throughput is 1 byte per 2 cycles. Backpressure holds `sort_addr` stable, so `m_data` stays stable while `m_valid`=1.
- FAULT (1 cycle):
  - `err`<=1 (sticky, cleared only by `rst`).
  - `sort_nrst`<=0 for exactly one cycle, then go LOAD, `cnt`=0. Any partial frame is lost.
- LOAD must not accept bytes while `sort_nrst`=0 or `sort_ready`=0 (covered by the `s_ready` expression).
- Width rules: `wd` is `$clog2(WATCHDOG+1)` bits and saturates; no arithmetic on data bytes.
- Simultaneous `rst` with any handshake: `rst` wins, nothing is written.

Decomposition:
- Shared package `sorter_pkg`:
  - state enum typedef `seq_state_t` {LOAD, KICK, WAIT, DRAIN, FAULT}
  - constants `SORT_WORDS`=8, `SORT_AW`=3, `DATA_W`=8
- One natural sub-module: `sort_watchdog` (load/count/expire counter with saturate), instanced for `wd`.
- Top-level wrapper, outside this block: `sort_frame_sequencer` plus `Sorter`.

Test Plan:
- Load 8'h{05,03,07,01,08,02,06,04}, `m_ready`=1:
  - `sort_start` pulses exactly once, 1 cycle after the 8th input handshake.
  - Output is 01..08 in order; `m_last` only with 08; `busy` falls after it.
- Already-sorted frame {00..07} and reverse frame {FF,FE,..,F8}: outputs ascending; `err`=0; WAIT length < `WATCHDOG`.
- Random `s_valid` gaps and `m_ready` toggling every cycle:
  - No byte lost or duplicated; `m_data` stable while `m_valid`&!`m_ready`.
  - `s_ready`=0 outside LOAD.
- Bench holds `sort_ready`=0 (stub `Sorter`), `WATCHDOG`=20:
  - FAULT is reached 20 cycles into WAIT; `err`=1 sticky.
  - `sort_nrst` is low for 1 cycle; sequencer returns to LOAD and accepts a new frame.
- Assert `rst` after 4 input bytes, then send a full new frame: only the new frame's 8 sorted bytes appear; `sort_nrst`=0 for the reset cycle.
- Back-to-back frames with the second frame's data offered during DRAIN: the second frame is accepted only after the first frame's `m_last` handshake.
